// File: rtl/load_reg_bank.sv
// Bank of CHANNELS independent WIDTH-bit registers with hold/load/clear/accumulate/dec/inc ops.
// Define LOAD_REG_BANK_SAT_EN to saturate instead of wrapping on accumulate/increment/decrement.
module load_reg_bank #(
  parameter int          WIDTH     = 16,
  parameter int          CHANNELS  = 3,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [3*CHANNELS-1:0]     op,
  input  logic [WIDTH*CHANNELS-1:0] din,
  output logic [WIDTH*CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0]       zero,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       upd
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_CLR  = 3'b010;
  localparam logic [2:0] OP_ACC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_INC  = 3'b101;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] val_q, val_d;
    logic             ovf_q, ovf_d;
    logic             upd_q, upd_d;
    logic [WIDTH-1:0] din_c;
    logic [2:0]       op_c;
    logic [WIDTH:0]   sum;

    assign din_c = din[g*WIDTH +: WIDTH];
    assign op_c  = op[3*g +: 3];
    assign sum   = {1'b0, val_q} + {1'b0, din_c};

    always_comb begin
      val_d = val_q;
      ovf_d = ovf_q;
      upd_d = 1'b0;
      if (clear) begin
        val_d = '0;
        ovf_d = 1'b0;
        upd_d = 1'b1;
      end else begin
        case (op_c)
          OP_LOAD: begin
            val_d = din_c;
            ovf_d = 1'b0;
            upd_d = 1'b1;
          end
          OP_CLR: begin
            val_d = '0;
            ovf_d = 1'b0;
            upd_d = 1'b1;
          end
          OP_ACC: begin
            upd_d = 1'b1;
            ovf_d = ovf_q | sum[WIDTH];
`ifdef LOAD_REG_BANK_SAT_EN
            val_d = sum[WIDTH] ? ONES : sum[WIDTH-1:0];
`else
            val_d = sum[WIDTH-1:0];
`endif
          end
          OP_DEC: begin
            upd_d = 1'b1;
            if (val_q == '0) begin
              ovf_d = 1'b1;
`ifdef LOAD_REG_BANK_SAT_EN
              val_d = '0;
`else
              val_d = ONES;
`endif
            end else begin
              val_d = val_q - ONE;
            end
          end
          OP_INC: begin
            upd_d = 1'b1;
            if (val_q == ONES) begin
              ovf_d = 1'b1;
`ifdef LOAD_REG_BANK_SAT_EN
              val_d = ONES;
`else
              val_d = '0;
`endif
            end else begin
              val_d = val_q + ONE;
            end
          end
          // OP_HOLD and the reserved codes keep state and do not pulse upd
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        val_q <= RST_V;
        ovf_q <= 1'b0;
        upd_q <= 1'b0;
      end else begin
        val_q <= val_d;
        ovf_q <= ovf_d;
        upd_q <= upd_d;
      end
    end

    assign dout[g*WIDTH +: WIDTH] = val_q;
    assign zero[g]                = (val_q == '0);
    assign ovf[g]                 = ovf_q;
    assign upd[g]                 = upd_q;
  end

  logic unused_op_hold;
  assign unused_op_hold = |OP_HOLD;

endmodule

// File: tb/tb_load_reg_bank.sv
// Directed bench for load_reg_bank (WIDTH=8, CHANNELS=3, RESET_VAL=0).
module tb_load_reg_bank;

  localparam int W = 8;
  localparam int C = 3;

  logic           clk;
  logic           rst_n;
  logic           clear;
  logic [3*C-1:0] op;
  logic [W*C-1:0] din;
  logic [W*C-1:0] dout;
  logic [C-1:0]   zero;
  logic [C-1:0]   ovf;
  logic [C-1:0]   upd;

  int tests = 0;
  int fails = 0;

  load_reg_bank #(.WIDTH(W), .CHANNELS(C), .RESET_VAL(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .op    (op),
    .din   (din),
    .dout  (dout),
    .zero  (zero),
    .ovf   (ovf),
    .upd   (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o2, input logic [2:0] o1, input logic [2:0] o0,
                       input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0);
    op  = {o2, o1, o0};
    din = {d2, d1, d0};
  endtask

  initial begin
    int iters;
    rst_n = 1'b0;
    clear = 1'b0;
    op    = '0;
    din   = '0;
    #1;
    chk("async_reset_t0", dout, 24'h0);
    step();
    step();
    chk("rst_dout", dout, 24'h0);
    chk("rst_zero", zero, 3'b111);
    chk("rst_ovf",  ovf,  3'b000);
    chk("rst_upd",  upd,  3'b000);
    rst_n = 1'b1;
    step();
    chk("hold_dout", dout, 24'h0);
    chk("hold_upd",  upd,  3'b000);

    // multiply 7x5: load ch0=7, ch1=5, clear ch2
    drive(3'b010, 3'b001, 3'b001, 8'd0, 8'd5, 8'd7);
    step();
    chk("mul_load_dout", dout, {8'd0, 8'd5, 8'd7});
    chk("mul_load_upd",  upd,  3'b111);
    chk("mul_load_zero", zero, 3'b100);
    iters = 0;
    drive(3'b011, 3'b100, 3'b000, 8'd7, 8'd0, 8'd0);
    while (zero[1] !== 1'b1 && iters < 20) begin
      step();
      iters++;
    end
    drive(3'b000, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0);
    chk("mul_iters",   iters,  5);
    chk("mul_product", dout[23:16], 8'd35);
    chk("mul_ch0",     dout[7:0],   8'd7);
    chk("mul_zero",    zero,  3'b010);
    chk("mul_ovf",     ovf,   3'b000);
    chk("mul_upd",     upd,   3'b110);
    step();
    chk("mul_upd_drop", upd, 3'b000);

    // accumulate overflow on ch2
    drive(3'b001, 3'b000, 3'b000, 8'd200, 8'd0, 8'd0);
    step();
    chk("acc_load", dout[23:16], 8'd200);
    drive(3'b011, 3'b000, 3'b000, 8'd100, 8'd0, 8'd0);
    step();
`ifdef LOAD_REG_BANK_SAT_EN
    chk("acc_ovf_val", dout[23:16], 8'd255);
`else
    chk("acc_ovf_val", dout[23:16], 8'd44);
`endif
    chk("acc_ovf_flag", ovf, 3'b100);
    drive(3'b011, 3'b000, 3'b000, 8'd1, 8'd0, 8'd0);
    step();
`ifdef LOAD_REG_BANK_SAT_EN
    chk("acc_sticky_val", dout[23:16], 8'd255);
`else
    chk("acc_sticky_val", dout[23:16], 8'd45);
`endif
    chk("acc_sticky_flag", ovf, 3'b100);
    chk("acc_upd", upd, 3'b100);
    drive(3'b001, 3'b000, 3'b000, 8'h10, 8'd0, 8'd0);
    step();
    chk("acc_load_clr_ovf", ovf, 3'b000);
    chk("acc_load_val", dout[23:16], 8'h10);

    // decrement underflow on ch1 (currently 0)
    drive(3'b000, 3'b100, 3'b000, 8'd0, 8'd0, 8'd0);
    step();
`ifdef LOAD_REG_BANK_SAT_EN
    chk("dec_val",  dout[15:8], 8'd0);
    chk("dec_zero", zero, 3'b010);
`else
    chk("dec_val",  dout[15:8], 8'd255);
    chk("dec_zero", zero, 3'b000);
`endif
    chk("dec_ovf", ovf, 3'b010);

    // increment wrap on ch0
    drive(3'b000, 3'b000, 3'b001, 8'd0, 8'd0, 8'hFF);
    step();
    drive(3'b000, 3'b000, 3'b101, 8'd0, 8'd0, 8'd0);
    step();
`ifdef LOAD_REG_BANK_SAT_EN
    chk("inc_val", dout[7:0], 8'hFF);
`else
    chk("inc_val", dout[7:0], 8'h00);
`endif
    chk("inc_ovf", ovf, 3'b011);

    // global clear beats op
    clear = 1'b1;
    drive(3'b001, 3'b001, 3'b001, 8'hAA, 8'hAA, 8'hAA);
    step();
    clear = 1'b0;
    drive(3'b000, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0);
    chk("clr_dout", dout, 24'h0);
    chk("clr_ovf",  ovf,  3'b000);
    chk("clr_upd",  upd,  3'b111);
    chk("clr_zero", zero, 3'b111);
    step();
    chk("clr_upd_drop", upd, 3'b000);

    // reserved ops and upd on same-value load
    drive(3'b000, 3'b000, 3'b001, 8'd0, 8'd0, 8'h33);
    step();
    drive(3'b111, 3'b000, 3'b110, 8'h55, 8'd0, 8'h77);
    step();
    chk("rsv_dout", dout, {8'd0, 8'd0, 8'h33});
    chk("rsv_upd",  upd,  3'b000);
    drive(3'b000, 3'b000, 3'b001, 8'd0, 8'd0, 8'h33);
    step();
    chk("same_load_upd", upd, 3'b001);
    chk("same_load_val", dout[7:0], 8'h33);
    drive(3'b000, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0);
    step();
    chk("same_load_upd_drop", upd, 3'b000);

    // async reset in the middle of an accumulate sequence
    drive(3'b011, 3'b000, 3'b000, 8'd5, 8'd0, 8'd0);
    step();
    chk("mid_acc_val", dout[23:16], 8'd5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 24'h0);
    chk("mid_rst_upd",  upd,  3'b000);
    chk("mid_rst_zero", zero, 3'b111);
    step();
    rst_n = 1'b1;
    drive(3'b000, 3'b000, 3'b001, 8'd0, 8'd0, 8'h5A);
    step();
    chk("post_rst_load", dout, {8'd0, 8'd0, 8'h5A});
    chk("post_rst_upd",  upd,  3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
